execute_md: RTL

EXECUTE_MD -- requirements
Module: execute_md

---
 rtl/execute_md.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_md.sv
// execute_md: execute stage with operand forwarding, ALU and an iterative multiply/divide unit.
// Optional feature macro EXECUTE_MD_SIGNED_EN: when defined md_signed is honoured, otherwise all mult/div is unsigned.
module execute_md #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        alu_ctrl_e,
  input  logic              alu_src_e,
  input  logic              reg_dst_e,
  input  logic [DATA_W-1:0] reg1_e,
  input  logic [DATA_W-1:0] reg2_e,
  input  logic [DATA_W-1:0] sign_imm_e,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [1:0]        forward_a_e,
  input  logic [1:0]        forward_b_e,
  input  logic [DATA_W-1:0] fwd_mem_val,
  input  logic [DATA_W-1:0] fwd_exec_val,
  input  logic              md_start,
  input  logic              md_op,
  input  logic              md_signed,
  input  logic              mfhi_e,
  input  logic              mflo_e,
  output logic [DATA_W-1:0] alu_out_e,
  output logic [DATA_W-1:0] write_data_e,
  output logic [REG_AW-1:0] write_reg_e,
  output logic [REG_AW-1:0] rs_hazard_e,
  output logic [REG_AW-1:0] rt_hazard_e,
  output logic              md_busy,
  output logic              md_done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_t;

  logic [DATA_W-1:0]        src_a;
  logic [DATA_W-1:0]        src_b;
  logic signed [DATA_W-1:0] src_a_s;
  logic signed [DATA_W-1:0] src_b_s;
  logic [DATA_W-1:0]        alu_res;

  md_state_t         state;
  md_state_t         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              start_ok;
  logic              last_step;
  logic              is_div;
  logic              dz_pend;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] op_m;
  logic [DATA_W-1:0] dvd_raw;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  // Forwarding muxes and ALU, all zero-latency
  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = fwd_mem_val;
      2'b10:   src_a = fwd_exec_val;
      default: src_a = reg1_e;
    endcase
    case (forward_b_e)
      2'b01:   write_data_e = fwd_mem_val;
      2'b10:   write_data_e = fwd_exec_val;
      default: write_data_e = reg2_e;
    endcase
  end

  assign src_b   = alu_src_e ? sign_imm_e : write_data_e;
  assign src_a_s = src_a;
  assign src_b_s = src_b;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_e)
      3'b000:  alu_res = src_a & src_b;
      3'b001:  alu_res = src_a | src_b;
      3'b010:  alu_res = src_a + src_b;
      3'b110:  alu_res = src_a - src_b;
      3'b111:  alu_res = (src_a_s < src_b_s) ? DATA_W'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  assign alu_out_e   = mfhi_e ? hi : (mflo_e ? lo : alu_res);
  assign write_reg_e = reg_dst_e ? rd_e : rt_e;
  assign rs_hazard_e = rs_e;
  assign rt_hazard_e = rt_e;

  // Operand conditioning: the iterative core always works on magnitudes
`ifdef EXECUTE_MD_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;
  logic neg_r;

  function automatic logic [DATA_W-1:0] negate_w(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] negate_2w(input logic [2*DATA_W-1:0] v, input logic en);
    return en ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

  assign neg_a = md_signed & src_a[DATA_W-1];
  assign neg_b = md_signed & write_data_e[DATA_W-1];
  assign mag_a = negate_w(src_a, neg_a);
  assign mag_b = negate_w(write_data_e, neg_b);

  // Quotient/product sign is the XOR of operand signs; remainder follows the dividend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start_ok) begin
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end
  end
`else
  logic unused_md_signed;
  assign unused_md_signed = md_signed;
  assign mag_a = src_a;
  assign mag_b = write_data_e;
`endif

  // One radix-2 step: shift-add multiply or restoring divide
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_m} : '0);
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, op_m};
  assign div_ge    = ~div_diff[DATA_W];

  always_comb begin
    if (is_div) begin
      step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end
  end

  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
`ifdef EXECUTE_MD_SIGNED_EN
    if (is_div) begin
      res_lo = negate_w(step_lo, neg_q);
      res_hi = negate_w(step_hi, neg_r);
    end else begin
      {res_hi, res_lo} = negate_2w({step_hi, step_lo}, neg_q);
    end
`endif
    if (dz_pend) begin
      res_hi = dvd_raw;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    last_step = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        md_busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        md_done = 1'b1;
        if (md_start) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture at launch, iterate in RUN, commit HI/LO on the final step only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      dz_pend  <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_m     <= '0;
      dvd_raw  <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (start_ok) begin
      cnt      <= '0;
      is_div   <= md_op;
      dz_pend  <= md_op & (write_data_e == '0);
      acc_hi   <= '0;
      acc_lo   <= md_op ? mag_a : mag_b;
      op_m     <= md_op ? mag_b : mag_a;
      dvd_raw  <= src_a;
      div_zero <= 1'b0;
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_step) begin
        cnt      <= '0;
        hi       <= res_hi;
        lo       <= res_lo;
        div_zero <= dz_pend;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
